// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard control unit:
// FSM state encoding, stall depths and the register-dependency helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } hcu_state_e;

  localparam int CNT_W_DEFAULT  = 16;
  localparam int BR_EX_LD_STALL = 2;
  localparam int LD_STALL       = 1;
  localparam int STALL_LEFT_W   = 2;

  // True when rd is a real register (not x0) and the ID instruction reads it.
  function automatic logic src_match(
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic       use_rs1,
    input logic [4:0] rs2,
    input logic       use_rs2
  );
    return (rd != 5'd0) && ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use / branch hazard detection with a RUN/STALL/FREEZE sequencer,
// memory-stall freeze handling and saturating performance counters.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             IF_ID_use_rs1,
  input  logic             IF_ID_use_rs2,
  input  logic             branch,
  input  logic             branch_taken,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_mem_read,
  input  logic             ID_EX_reg_write,
  input  logic [4:0]       EX_MEM_rd,
  input  logic             EX_MEM_mem_read,
  input  logic             mem_busy,
  input  logic             clr_cnt,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             ID_EX_bubble,
  output logic             IF_ID_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  hcu_state_e              state_reg, state_next;
  hcu_state_e              saved_state_reg, saved_state_next;
  hcu_state_e              eff_state;
  logic [STALL_LEFT_W-1:0] stall_left_reg, stall_left_next;

  logic ex_writes_rd;
  logic ex_match;
  logic mem_match;
  logic lu_hz;
  logic br_ex_ld;
  logic br_mem_ld;
  logic any_hz;

  // An EX instruction produces rd if it writes or loads; only loads stall,
  // plain ALU producers are covered by forwarding.
  assign ex_writes_rd = ID_EX_reg_write | ID_EX_mem_read;
  assign ex_match  = ex_writes_rd &&
                     src_match(ID_EX_rd, IF_ID_rs1, IF_ID_use_rs1, IF_ID_rs2, IF_ID_use_rs2);
  assign mem_match = src_match(EX_MEM_rd, IF_ID_rs1, IF_ID_use_rs1, IF_ID_rs2, IF_ID_use_rs2);

  assign lu_hz     = ID_EX_mem_read && ex_match;
  assign br_ex_ld  = branch && lu_hz;
  assign br_mem_ld = branch && EX_MEM_mem_read && mem_match;
  assign any_hz    = lu_hz || br_mem_ld;

  // FREEZE behaves as the state it interrupted once memory is ready again.
  assign eff_state = (state_reg == FREEZE) ? saved_state_reg : state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      saved_state_reg <= RUN;
      stall_left_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      saved_state_reg <= saved_state_next;
      stall_left_reg  <= stall_left_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    saved_state_next = saved_state_reg;
    stall_left_next  = stall_left_reg;
    if (mem_busy) begin
      state_next       = FREEZE;
      saved_state_next = eff_state;
    end else begin
      case (eff_state)
        STALL: begin
          stall_left_next = (stall_left_reg > STALL_LEFT_W'(1)) ?
                            stall_left_reg - STALL_LEFT_W'(1) : '0;
          state_next      = (stall_left_reg > STALL_LEFT_W'(1)) ? STALL : RUN;
        end
        default: begin
          // The branch-on-EX-load case needs stalls beyond the one taken now.
          if (br_ex_ld) begin
            state_next      = STALL;
            stall_left_next = STALL_LEFT_W'(BR_EX_LD_STALL - LD_STALL);
          end else begin
            state_next      = RUN;
            stall_left_next = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    IF_ID_write  = 1'b0;
    ID_EX_bubble = 1'b1;
    IF_ID_flush  = 1'b0;
    pipe_hold    = 1'b0;
    if (rst_n) begin
      if (mem_busy) begin
        pipe_hold    = 1'b1;
        ID_EX_bubble = 1'b0;
      end else if ((eff_state == STALL) || any_hz) begin
        ID_EX_bubble = 1'b1;
      end else begin
        pc_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_bubble = 1'b0;
        IF_ID_flush  = branch_taken;
      end
    end
  end

  logic [2:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [3];

  assign cnt_inc = {pipe_hold, IF_ID_flush, ID_EX_bubble};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_inc[gi]),
      .clr   (clr_cnt),
      .count (cnt_val[gi])
    );
  end

  assign stall_cnt  = cnt_val[0];
  assign flush_cnt  = cnt_val[1];
  assign freeze_cnt = cnt_val[2];

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: a 16-bit-counter instance and a
// 2-bit-counter instance share stimulus so saturation can be observed.
module tb_hazard_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  IF_ID_rs1, IF_ID_rs2, ID_EX_rd, EX_MEM_rd;
  logic        IF_ID_use_rs1, IF_ID_use_rs2, branch, branch_taken;
  logic        ID_EX_mem_read, ID_EX_reg_write, EX_MEM_mem_read, mem_busy, clr_cnt;

  logic        pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipe_hold;
  logic [15:0] stall_cnt, flush_cnt, freeze_cnt;
  logic        n_pc_write, n_IF_ID_write, n_ID_EX_bubble, n_IF_ID_flush, n_pipe_hold;
  logic [1:0]  n_stall_cnt, n_flush_cnt, n_freeze_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_control_unit dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
    .branch(branch), .branch_taken(branch_taken),
    .ID_EX_rd(ID_EX_rd), .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_reg_write(ID_EX_reg_write),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_mem_read(EX_MEM_mem_read),
    .mem_busy(mem_busy), .clr_cnt(clr_cnt),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .ID_EX_bubble(ID_EX_bubble),
    .IF_ID_flush(IF_ID_flush), .pipe_hold(pipe_hold),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  hazard_control_unit #(.CNT_W(2)) dut_narrow (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
    .branch(branch), .branch_taken(branch_taken),
    .ID_EX_rd(ID_EX_rd), .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_reg_write(ID_EX_reg_write),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_mem_read(EX_MEM_mem_read),
    .mem_busy(mem_busy), .clr_cnt(clr_cnt),
    .pc_write(n_pc_write), .IF_ID_write(n_IF_ID_write), .ID_EX_bubble(n_ID_EX_bubble),
    .IF_ID_flush(n_IF_ID_flush), .pipe_hold(n_pipe_hold),
    .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt), .freeze_cnt(n_freeze_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    IF_ID_rs1 = 5'd0; IF_ID_rs2 = 5'd0; IF_ID_use_rs1 = 1'b0; IF_ID_use_rs2 = 1'b0;
    branch = 1'b0; branch_taken = 1'b0;
    ID_EX_rd = 5'd0; ID_EX_mem_read = 1'b0; ID_EX_reg_write = 1'b0;
    EX_MEM_rd = 5'd0; EX_MEM_mem_read = 1'b0;
    mem_busy = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic ex_load(input logic [4:0] rd);
    ID_EX_rd = rd; ID_EX_mem_read = 1'b1; ID_EX_reg_write = 1'b1;
  endtask

  task automatic clear_counters();
    idle();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  task automatic expect_outputs(input string tag, input logic [4:0] exp);
    check_eq(tag, {27'd0, pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipe_hold},
             {27'd0, exp});
  endtask

  initial begin
    // Reset with hazardous inputs present: outputs must ignore them.
    idle();
    mem_busy = 1'b1; branch_taken = 1'b1;
    ex_load(5'd5); IF_ID_rs1 = 5'd5; IF_ID_use_rs1 = 1'b1;
    #2;
    expect_outputs("reset_outputs", 5'b00100);
    tick();
    check_eq("reset_stall_cnt", stall_cnt, 0);
    check_eq("reset_freeze_cnt", freeze_cnt, 0);
    tick();
    rst_n = 1'b1;
    idle();
    settle();
    expect_outputs("post_reset_run", 5'b11000);

    // Scenario 1: load-use on x5 -> one stall cycle.
    ex_load(5'd5); IF_ID_rs1 = 5'd5; IF_ID_use_rs1 = 1'b1;
    settle();
    expect_outputs("s1_stall", 5'b00100);
    tick();
    idle();
    settle();
    expect_outputs("s1_release", 5'b11000);
    check_eq("s1_stall_cnt", stall_cnt, 1);

    // Scenario 2: branch on x7 with EX load -> RUN, STALL, RUN.
    clear_counters();
    branch = 1'b1; IF_ID_rs1 = 7; IF_ID_use_rs1 = 1'b1; ex_load(5'd7);
    settle();
    expect_outputs("s2_stall1", 5'b00100);
    tick();
    ID_EX_mem_read = 1'b0; ID_EX_reg_write = 1'b0; ID_EX_rd = 5'd0;
    branch_taken = 1'b1;
    settle();
    expect_outputs("s2_stall2_fsm", 5'b00100);
    tick();
    settle();
    expect_outputs("s2_release_taken", 5'b11010);
    check_eq("s2_stall_cnt", stall_cnt, 2);

    // Scenario 3: branch on x3 with ALU producers -> forwarded, taken flushes.
    clear_counters();
    branch = 1'b1; branch_taken = 1'b1; IF_ID_rs1 = 5'd3; IF_ID_use_rs1 = 1'b1;
    ID_EX_rd = 5'd3; ID_EX_reg_write = 1'b1; EX_MEM_rd = 5'd3;
    settle();
    expect_outputs("s3_forward_flush", 5'b11010);
    tick();
    idle();
    settle();
    expect_outputs("s3_after", 5'b11000);
    check_eq("s3_flush_cnt", flush_cnt, 1);
    check_eq("s3_stall_cnt", stall_cnt, 0);

    // Branch with a MEM-stage load on rs2: one stall, taken ignored while stalled.
    branch = 1'b1; branch_taken = 1'b1; IF_ID_rs2 = 5'd9; IF_ID_use_rs2 = 1'b1;
    EX_MEM_rd = 5'd9; EX_MEM_mem_read = 1'b1;
    settle();
    expect_outputs("br_mem_ld_stall", 5'b00100);
    tick();
    EX_MEM_mem_read = 1'b0; EX_MEM_rd = 5'd0;
    settle();
    expect_outputs("br_mem_ld_release", 5'b11010);

    // Scenario 4: freeze three cycles during the second branch stall.
    clear_counters();
    branch = 1'b1; IF_ID_rs1 = 7; IF_ID_use_rs1 = 1'b1; ex_load(5'd7);
    settle();
    expect_outputs("s4_stall1", 5'b00100);
    tick();
    ID_EX_mem_read = 1'b0; ID_EX_reg_write = 1'b0; ID_EX_rd = 5'd0;
    mem_busy = 1'b1;
    settle();
    expect_outputs("s4_freeze1", 5'b00001);
    tick();
    ex_load(5'd7);
    settle();
    expect_outputs("s4_freeze2_over_hazard", 5'b00001);
    tick();
    ID_EX_mem_read = 1'b0; ID_EX_reg_write = 1'b0; ID_EX_rd = 5'd0;
    settle();
    expect_outputs("s4_freeze3", 5'b00001);
    tick();
    mem_busy = 1'b0;
    settle();
    expect_outputs("s4_resumed_stall", 5'b00100);
    tick();
    settle();
    expect_outputs("s4_release", 5'b11000);
    check_eq("s4_freeze_cnt", freeze_cnt, 3);
    check_eq("s4_stall_cnt", stall_cnt, 2);

    // Scenario 5: x0 never hazards; narrow counters saturate; clear beats inc.
    clear_counters();
    ex_load(5'd0); IF_ID_rs1 = 5'd0; IF_ID_use_rs1 = 1'b1;
    settle();
    expect_outputs("s5_x0_no_stall", 5'b11000);
    tick();
    idle();
    ex_load(5'd4); IF_ID_rs2 = 5'd4; IF_ID_use_rs2 = 1'b1;
    repeat (5) tick();
    check_eq("s5_wide_stall_cnt", stall_cnt, 5);
    check_eq("s5_narrow_sat", n_stall_cnt, 3);
    clr_cnt = 1'b1;
    settle();
    check_eq("s5_bubble_with_clr", ID_EX_bubble, 1);
    tick();
    idle();
    settle();
    check_eq("s5_clr_wide", stall_cnt, 0);
    check_eq("s5_clr_narrow", n_stall_cnt, 0);

    // Scenario 6: reset pulse while in STALL.
    branch = 1'b1; IF_ID_rs1 = 7; IF_ID_use_rs1 = 1'b1; ex_load(5'd7);
    settle();
    expect_outputs("s6_stall1", 5'b00100);
    tick();
    rst_n = 1'b0;
    mem_busy = 1'b1; branch_taken = 1'b1;
    settle();
    expect_outputs("s6_reset_outputs", 5'b00100);
    check_eq("s6_reset_stall_cnt", stall_cnt, 0);
    tick();
    rst_n = 1'b1;
    idle();
    settle();
    expect_outputs("s6_run_after_reset", 5'b11000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 The block SHALL provide parameter CNT_W, default 16, meaning the width of each performance counter.
REQ-002 The block SHALL provide port clk  in  1  pipeline clock; all state is updated on its rising edge.
REQ-003 The block SHALL provide port rst_n  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL provide ports IF_ID_rs1, IF_ID_rs2  in  5 each  source registers of the instruction in ID.
REQ-005 The block SHALL provide ports IF_ID_use_rs1, IF_ID_use_rs2  in  1 each  the instruction in ID reads rs1/rs2.
REQ-006 The block SHALL provide port branch  in  1  the instruction in ID is a conditional branch.
REQ-007 The block SHALL provide port branch_taken  in  1  the ID-stage comparator resolved the branch as taken.
REQ-008 The block SHALL provide ports ID_EX_rd (in, 5), ID_EX_mem_read (in, 1) and ID_EX_reg_write (in, 1), the destination, load flag and write flag of the instruction in EX.
REQ-009 The block SHALL provide ports EX_MEM_rd (in, 5) and EX_MEM_mem_read (in, 1), the destination and load flag of the instruction in MEM.
REQ-010 The block SHALL provide port mem_busy  in  1  data memory is not ready this cycle.
REQ-011 The block SHALL provide port clr_cnt  in  1  synchronous clear of all performance counters.
REQ-012 The block SHALL provide ports pc_write (out, 1) and IF_ID_write (out, 1), the PC and IF/ID register enables.
REQ-013 The block SHALL provide ports ID_EX_bubble (out, 1) and IF_ID_flush (out, 1), which insert a NOP into ID/EX and zero IF/ID respectively.
REQ-014 The block SHALL provide port pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
REQ-015 The block SHALL provide ports stall_cnt, flush_cnt and freeze_cnt  out  CNT_W each  performance counters.

Function
REQ-016 The block SHALL raise lu_hz when ID_EX_mem_read=1, ID_EX_rd!=0, and ID_EX_rd matches a used rs1 or rs2.
REQ-017 The block SHALL raise br_ex_ld when branch=1, ID_EX_mem_read=1, ID_EX_rd!=0, and ID_EX_rd matches a used source; a branch total stall of 2 cycles SHALL result.
REQ-018 The block SHALL raise br_mem_ld when branch=1, EX_MEM_mem_read=1, EX_MEM_rd!=0, and EX_MEM_rd matches a used source; a total stall of 1 cycle SHALL result.
REQ-019 The block SHALL NOT stall a branch whose only dependency is a non-load in EX or MEM, because that case is forwarded.
REQ-020 The FSM SHALL have exactly three states: RUN, STALL and FREEZE.
REQ-021 In RUN with mem_busy=0 and any hazard, the block SHALL assert stall outputs in the same cycle: pc_write=0, IF_ID_write=0, ID_EX_bubble=1.
REQ-022 On a br_ex_ld detection in RUN, the FSM SHALL go to STALL with stall_left=1; every other hazard SHALL keep the FSM in RUN, and the next-cycle re-evaluation covers any residual stall.
REQ-023 In STALL, the block SHALL apply the REQ-021 stall outputs unconditionally, decrement stall_left, and return to RUN when stall_left reaches 0.
REQ-024 In RUN with no hazard, the block SHALL drive pc_write=1, IF_ID_write=1 and ID_EX_bubble=0.
REQ-025 In RUN with no hazard and branch_taken=1, IF_ID_flush SHALL be 1 for that cycle; branch_taken SHALL be ignored in every other situation.
REQ-026 When mem_busy=1 in any state, the block SHALL drive pipe_hold=1, pc_write=0, IF_ID_write=0, ID_EX_bubble=0 and IF_ID_flush=0 in the same cycle.
REQ-027 When mem_busy=1, the FSM SHALL enter FREEZE and save the return state and stall_left.
REQ-028 In FREEZE, once mem_busy=0, the block SHALL restore the saved state and stall_left that cycle with no stall cycle lost or added; mem_busy has priority over every hazard.
REQ-029 The counters SHALL saturate at 2^CNT_W-1.
REQ-030 stall_cnt SHALL increment each cycle ID_EX_bubble=1, flush_cnt each cycle IF_ID_flush=1, and freeze_cnt each cycle pipe_hold=1.
REQ-031 clr_cnt=1 SHALL zero all counters on the next edge, overriding any increment in the same cycle.
REQ-032 Register x0 SHALL never create a hazard.

Reset
REQ-033 While rst_n=0, the block SHALL hold state=RUN, stall_left=0, saved state=RUN and all counters=0.
REQ-034 While rst_n=0, the outputs SHALL be pc_write=0, IF_ID_write=0, ID_EX_bubble=1, IF_ID_flush=0 and pipe_hold=0, independent of the other inputs.
REQ-035 If reset is asserted during STALL or FREEZE, the block SHALL abort immediately, and after release the first cycle SHALL be evaluated as RUN.

Structure
REQ-036 The state enum, the stall-depth constants (BR_EX_LD_STALL=2, LD_STALL=1) and the CNT_W default SHALL live in shared package hazard_pkg.
REQ-037 One sub-module, sat_counter (parameter W; inputs inc and clr), SHALL be instantiated three times.
REQ-038 Hazard detection and output decode SHALL be combinational, and the FSM and counters SHALL be registered.

Verification
REQ-039 Scenario 1: ID_EX load to x5, ID instruction reads x5 -> 1 cycle with pc_write=0 and ID_EX_bubble=1; stall_cnt=1.
REQ-040 Scenario 2: branch in ID reads x7, ID_EX load to x7 -> 2 consecutive stall cycles (RUN->STALL->RUN); stall_cnt=2.
REQ-041 Scenario 3: branch reads x3, ID_EX ALU write to x3 -> no stall; branch_taken=1 gives IF_ID_flush=1 for 1 cycle; flush_cnt=1.
REQ-042 Scenario 4: mem_busy=1 for 3 cycles starting at the second cycle of Scenario 2 -> pipe_hold=1 for 3 cycles, then exactly 1 remaining stall cycle; freeze_cnt=3, stall_cnt=2.
REQ-043 Scenario 5: load to x0 with a dependent reader -> no stall; CNT_W=2 with 5 stalls -> stall_cnt=3; clr_cnt=1 coincident with a stall -> stall_cnt=0.
REQ-044 Scenario 6: rst_n low for 1 cycle mid-STALL -> outputs at reset values, and the next cycle with no hazard gives pc_write=1.
